// File: rtl/song_recorder.sv
// Song recorder: captures live notes as (note, duration) entries into a song RAM read back through a 1-cycle port.
// Optional build macro SONG_RECORDER_TRIM_REST_EN drops a trailing rest segment when a take is stopped.
module song_recorder #(
  parameter int NOTE_W      = 5,
  parameter int DUR_W       = 8,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int TICK_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [NOTE_W-1:0] rd_note,
  output logic [DUR_W-1:0]  rd_dur,
  output logic [ADDR_W:0]   length,
  output logic              recording,
  output logic              full
);

  localparam int PS_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(TICK_CYCLES - 1);
  localparam logic [PS_W-1:0]   PS_ONE   = PS_W'(1);
  localparam logic [DUR_W-1:0]  DUR_MAX  = {DUR_W{1'b1}};
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W:0]     length_r, length_s;
  logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_s;
  logic                full_r, full_s;
  logic [DUR_W-1:0]    dur_cnt_r, dur_cnt_s;
  logic [PS_W-1:0]     prescaler_r, prescaler_s;
  logic [NOTE_W-1:0]   cur_note_r, cur_note_s;
  logic                recording_r;
  logic                commit_s;
  logic [NOTE_W-1:0]   rd_note_r;
  logic [DUR_W-1:0]    rd_dur_r;
  logic [NOTE_W+DUR_W-1:0] mem_r [DEPTH];

  // Next-state, segment timing and commit decision
  always_comb begin
    state_s     = state_r;
    length_s    = length_r;
    wr_ptr_s    = wr_ptr_r;
    full_s      = full_r;
    dur_cnt_s   = dur_cnt_r;
    prescaler_s = prescaler_r;
    cur_note_s  = cur_note_r;
    commit_s    = 1'b0;
    if (rec_start) begin
      state_s  = S_ARMED;
      length_s = '0;
      wr_ptr_s = '0;
      full_s   = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: state_s = S_IDLE;
        S_ARMED: begin
          if (rec_stop) begin
            state_s = S_DONE;
          end else if (note_in != '0) begin
            cur_note_s  = note_in;
            dur_cnt_s   = DUR_ONE;
            prescaler_s = '0;
            state_s     = S_CAPTURE;
          end else begin
            state_s = S_ARMED;
          end
        end
        S_CAPTURE: begin
          if (rec_stop) begin
            state_s = S_DONE;
`ifdef SONG_RECORDER_TRIM_REST_EN
            commit_s = (cur_note_r != '0);
`else
            commit_s = 1'b1;
`endif
          end else if (note_in != cur_note_r) begin
            commit_s    = 1'b1;
            cur_note_s  = note_in;
            dur_cnt_s   = DUR_ONE;
            prescaler_s = '0;
          end else if (prescaler_r == PS_LAST) begin
            prescaler_s = '0;
            // A saturated duration splits the note instead of overflowing
            if (dur_cnt_r == DUR_MAX) begin
              commit_s  = 1'b1;
              dur_cnt_s = DUR_ONE;
            end else begin
              dur_cnt_s = dur_cnt_r + DUR_ONE;
            end
          end else begin
            prescaler_s = prescaler_r + PS_ONE;
          end
          if (commit_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
            length_s = length_r + LEN_ONE;
            if (length_r == LEN_LAST) begin
              full_s  = 1'b1;
              state_s = S_DONE;
            end else begin
              full_s = full_r;
            end
          end else begin
            wr_ptr_s = wr_ptr_r;
          end
        end
        S_DONE: state_s = S_DONE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Control and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      length_r    <= '0;
      wr_ptr_r    <= '0;
      full_r      <= 1'b0;
      dur_cnt_r   <= '0;
      prescaler_r <= '0;
      cur_note_r  <= '0;
      recording_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      length_r    <= length_s;
      wr_ptr_r    <= wr_ptr_s;
      full_r      <= full_s;
      dur_cnt_r   <= dur_cnt_s;
      prescaler_r <= prescaler_s;
      cur_note_r  <= cur_note_s;
      recording_r <= (state_s == S_ARMED) || (state_s == S_CAPTURE);
    end
  end

  // Song RAM write port
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[wr_ptr_r] <= {cur_note_r, dur_cnt_r};
    end
  end

  // Synchronous read port; a colliding write is seen on the following read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_note_r <= '0;
      rd_dur_r  <= '0;
    end else if (rd_en) begin
      {rd_note_r, rd_dur_r} <= mem_r[rd_addr];
    end
  end

  assign rd_note   = rd_note_r;
  assign rd_dur    = rd_dur_r;
  assign length    = length_r;
  assign recording = recording_r;
  assign full      = full_r;

endmodule
